sd_adc_decimator: RTL and testbench

//  Receive-side counterpart of the sigma-delta DAC path: converts a 1-bit sigma-delta

---
 rtl/sd_adc_decimator.sv | 220 ++++++++++++++++++++++
 tb/tb_sd_adc_decimator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_adc_decimator.sv
// sd_adc_decimator: 1-bit sigma-delta bitstream to 16-bit signed PCM.
// Signal chain: +/-1 mapping -> three cascaded integrators -> decimate by 2**LOG2_R
// -> three pipelined combs (differential delay 1) -> arithmetic scale -> clamp to
// 16 bits -> single-entry output register with valid/ready handshake.
//
// Handshake: output_data is offered while out_valid is high. A transfer happens on
// an enabled clock edge where out_valid && out_ready are both high. output_data stays
// stable until that transfer, unless a newer sample overwrites it. An overwrite of a
// sample that was never transferred sets the sticky overrun flag. out_ready is
// ignored while out_valid is low, and no transfer happens while clk_enable is low.
module sd_adc_decimator #(
  parameter int LOG2_R = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] output_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  // Integrator/comb width: 2 bits for the +/-1 input plus 3*LOG2_R bits of CIC gain.
  localparam int ACC_W = 2 + 3 * LOG2_R;
  // Right shift that brings the CIC gain R**3 down to a 16-bit full scale.
  localparam int SHIFT = 3 * LOG2_R - 15;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
  localparam logic [1:0]              WARM_DONE = 2'd3;

  // ---------------------------------------------------------------------------
  // Input mapping and integrator datapath
  // ---------------------------------------------------------------------------
  logic                    accept;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] integ1;
  logic signed [ACC_W-1:0] integ2;
  logic signed [ACC_W-1:0] integ3;
  logic signed [ACC_W-1:0] integ1_next;
  logic signed [ACC_W-1:0] integ2_next;
  logic signed [ACC_W-1:0] integ3_next;

  // A bit is taken only when the whole block is enabled.
  assign accept = clk_enable & bit_valid;

  // 1 -> +1, 0 -> -1, sign-extended to the accumulator width.
  assign x_ext = bit_in ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

  // The cascade is combinational within one input sample, so the decimation
  // strobe can capture integrator 3 as updated by the very bit that raises it.
  assign integ1_next = integ1 + x_ext;
  assign integ2_next = integ2 + integ1_next;
  assign integ3_next = integ3 + integ2_next;

  // Integrators: modular two's-complement accumulation, wrap-around is expected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      integ1 <= '0;
      integ2 <= '0;
      integ3 <= '0;
    end else if (accept) begin
      integ1 <= integ1_next;
      integ2 <= integ2_next;
      integ3 <= integ3_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Decimation phase
  // ---------------------------------------------------------------------------
  logic [LOG2_R-1:0] phase;
  logic              strobe;

  // Last bit of a frame (phase R-1) produces one decimated sample.
  assign strobe = accept && (phase == {LOG2_R{1'b1}});

  // Phase counter: counts accepted bits, wraps naturally from R-1 to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (accept) begin
      phase <= phase + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Comb pipeline: one stage per enabled clock, independent of bit_valid.
  // Stage valid flags travel with the data so a reset mid-flight drops it.
  // ---------------------------------------------------------------------------
  logic                    stage0_valid;
  logic                    stage1_valid;
  logic                    stage2_valid;
  logic signed [ACC_W-1:0] comb_in;
  logic signed [ACC_W-1:0] comb1;
  logic signed [ACC_W-1:0] comb2;
  logic signed [ACC_W-1:0] comb3;
  logic signed [ACC_W-1:0] delay1;
  logic signed [ACC_W-1:0] delay2;
  logic signed [ACC_W-1:0] delay3;
  logic                    stage3_fire;

  // Decimation capture: latch integrator 3 at the strobe edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage0_valid <= 1'b0;
      comb_in      <= '0;
    end else if (clk_enable) begin
      stage0_valid <= strobe;
      if (strobe) begin
        comb_in <= integ3_next;
      end
    end
  end

  // Comb stage 1: first difference against the previous decimated sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage1_valid <= 1'b0;
      comb1        <= '0;
      delay1       <= '0;
    end else if (clk_enable) begin
      stage1_valid <= stage0_valid;
      if (stage0_valid) begin
        comb1  <= comb_in - delay1;
        delay1 <= comb_in;
      end
    end
  end

  // Comb stage 2: second difference.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage2_valid <= 1'b0;
      comb2        <= '0;
      delay2       <= '0;
    end else if (clk_enable) begin
      stage2_valid <= stage1_valid;
      if (stage1_valid) begin
        comb2  <= comb1 - delay2;
        delay2 <= comb1;
      end
    end
  end

  // Comb stage 3 result feeds the scaler directly and lands in the output register.
  assign comb3       = comb2 - delay3;
  assign stage3_fire = clk_enable && stage2_valid;

  // Comb stage 3 delay element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      delay3 <= '0;
    end else if (stage3_fire) begin
      delay3 <= comb2;
    end
  end

  // ---------------------------------------------------------------------------
  // Scale and saturate
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] scaled;
  logic signed [ACC_W-1:0] clamped;

  assign scaled = comb3 >>> SHIFT;

  // Clamp the scaled value into the signed 16-bit range.
  always_comb begin
    clamped = scaled;
    if (scaled > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (scaled < SAT_MIN) begin
      clamped = SAT_MIN;
    end
  end

  // ---------------------------------------------------------------------------
  // Warm-up: the combs hold zero history for the first three decimated samples,
  // so those results are dropped.
  // ---------------------------------------------------------------------------
  logic [1:0] warm_cnt;
  logic       load;

  assign load = stage3_fire && (warm_cnt == WARM_DONE);

  // Warm-up counter: counts stage-3 results, saturates at 3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt <= '0;
    end else if (stage3_fire && (warm_cnt != WARM_DONE)) begin
      warm_cnt <= warm_cnt + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------

  // Output register: a new sample has priority over a transfer on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      output_data <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else if (clk_enable) begin
      if (load) begin
        output_data <= clamped[15:0];
        out_valid   <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_adc_decimator.sv
// Testbench for sd_adc_decimator: directed phases with random bit patterns,
// checked against a frame-level CIC reference (impulse response convolution).
module tb_sd_adc_decimator;

  localparam int LOG2_R = 6;
  localparam int R      = 1 << LOG2_R;
  localparam int SHIFT  = 3 * LOG2_R - 15;
  localparam int NTAP   = 3 * R - 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        bit_in;
  logic        bit_valid;
  logic        out_ready;
  logic [15:0] output_data;
  logic        out_valid;
  logic        overrun;

  always #5 clk = ~clk;

  sd_adc_decimator #(.LOG2_R(LOG2_R)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .output_data (output_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
  );

  // ---------------- reference model state ----------------
  int          n_assert;
  int          n_fail;
  int          h[NTAP];
  int          xh[$];
  logic [15:0] exp_q[$];
  int          due_q[$];
  int          en_cnt;
  int          nbits;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_over;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CIC impulse response: three length-R boxcars convolved together.
  task automatic build_h();
    int h2[2*R-1];
    foreach (h2[i]) h2[i] = 0;
    foreach (h[i]) h[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++)
        h2[i+j] += 1;
    for (int i = 0; i < 2*R-1; i++)
      for (int j = 0; j < R; j++)
        h[i+j] += h2[i];
  endtask

  // Decimated output for the frame whose last bit is the newest in history.
  function automatic logic [15:0] frame_result();
    int n;
    int y;
    int s;
    n = xh.size() - 1;
    y = 0;
    for (int j = 0; j < NTAP; j++)
      if (n - j >= 0) y += h[j] * xh[n-j];
    s = y >>> SHIFT;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic model_reset();
    xh.delete();
    exp_q.delete();
    due_q.delete();
    en_cnt  = 0;
    nbits   = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_over  = 1'b0;
  endtask

  // ---------------- driver: one clock, update model, compare ----------------
  task automatic step();
    logic [15:0] ld_val;
    @(posedge clk);
    if (clk_enable) begin
      en_cnt++;
      if (due_q.size() > 0 && due_q[0] == en_cnt) begin
        ld_val = exp_q.pop_front();
        void'(due_q.pop_front());
        if (m_valid && !out_ready) m_over = 1'b1;
        m_data  = ld_val;
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (bit_valid) begin
        xh.push_back(bit_in ? 1 : -1);
        nbits++;
        if ((nbits % R == 0) && (nbits / R >= 4)) begin
          exp_q.push_back(frame_result());
          due_q.push_back(en_cnt + 3);
        end
      end
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("output_data", {16'd0, output_data}, {16'd0, m_data});
    check("overrun", {31'd0, overrun}, {31'd0, m_over});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int first;
    int sd;
    n_assert   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    clk_enable = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    out_ready  = 1'b1;
    build_h();
    model_reset();

    // Reset values
    #12;
    check("rst_data", {16'd0, output_data}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: constant ones -> saturated positive, first valid 3 clks after bit 4R-1
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    first     = -1;
    for (int i = 0; i < 5*R; i++) begin
      step();
      if (first < 0 && out_valid) first = i;
    end
    check("first_valid_step", first, 4*R + 2);
    check("ones_sat", {16'd0, output_data}, 32'h7fff);
    check("ones_overrun", {31'd0, overrun}, 32'd0);

    // 2: constant zeros -> saturated negative; then alternating -> zero
    bit_in = 1'b0;
    for (int i = 0; i < 4*R; i++) step();
    check("zeros_sat", {16'd0, output_data}, 32'h8000);
    for (int i = 0; i < 4*R; i++) begin
      bit_in = (i % 2 == 0);
      step();
    end
    check("alt_zero", {16'd0, output_data}, 32'd0);

    // 3: duty 0.75 -> +16384 (+/-1)
    for (int i = 0; i < 4*R; i++) begin
      bit_in = (i % 4 != 3);
      step();
    end
    sd = int'($signed(output_data));
    check("duty75", (sd >= 16383 && sd <= 16385) ? 32'd1 : 32'd0, 32'd1);

    // 4: consumer stalled for two frames -> overrun, newest sample kept
    out_ready = 1'b0;
    for (int i = 0; i < 2*R; i++) begin
      bit_in = 1'($urandom_range(0, 1));
      step();
    end
    check("stall_overrun", {31'd0, overrun}, 32'd1);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check("drain_drop", {31'd0, out_valid}, 32'd0);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // 5: bit_valid every other clk, clk_enable low for 5 clks mid-frame
    for (int i = 0; i < 8*R; i++) begin
      bit_in     = 1'($urandom_range(0, 1));
      bit_valid  = (i % 2 == 0);
      clk_enable = !(i >= 100 && i < 105);
      step();
    end
    clk_enable = 1'b1;
    bit_valid  = 1'b1;

    // 6: reset at phase 30 of a frame
    for (int i = 0; i < 2*R && (nbits % R) != 30; i++) begin
      bit_in = 1'($urandom_range(0, 1));
      step();
    end
    check("phase30_reached", nbits % R, 30);
    reset = 1'b0;
    #1;
    check("midrst_data", {16'd0, output_data}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4*R + 2; i++) begin
      bit_in = 1'($urandom_range(0, 1));
      step();
    end
    check("warmup_discard", {31'd0, out_valid}, 32'd0);
    bit_in = 1'($urandom_range(0, 1));
    step();
    check("first_after_rst", {31'd0, out_valid}, 32'd1);
    check("no_overrun_after_rst", {31'd0, overrun}, 32'd0);

    // 7: fully random bits, bit_valid, clk_enable and out_ready
    for (int i = 0; i < 12*R; i++) begin
      bit_in     = 1'($urandom_range(0, 1));
      bit_valid  = ($urandom_range(0, 3) != 0);
      clk_enable = ($urandom_range(0, 9) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
